obi_sram_bridge: RTL
====================

// Module: obi_sram_bridge
// PURPOSE
//  OBI slave that terminates the shared port of the 2:1 OBI mux (shr_* side) and drives one
//  single-port macro SRAM (OpenRAM-style: active-low CS/WE, per-byte write mask).
//  Issues SRAM commands on grant, times the read latency, and returns rvalid/rdata.
//  Writes return no response, matching the mux's read-only response tracking.
// PARAMETERS
//  ADDR_WIDTH    10           SRAM word-address width (depth = 2**ADDR_WIDTH words of 32 bit)
//  READ_LATENCY  1            cycles from command cycle to valid sram_dout_i; legal 1..4
//  BASE_ADDR     32'h0000_0000 byte base of the window; low ADDR_WIDTH+2 bits must be 0
// PORTS
//  clk_i         in   1   clock
//  rst_ni        in   1   asynchronous active-low reset
//  req_i         in   1   OBI request
//  gnt_o         out  1   OBI grant
//  addr_i        in   32  OBI byte address
//  we_i          in   1   OBI write enable
//  be_i          in   4   OBI byte enables
//  wdata_i       in   32  OBI write data
//  rvalid_o      out  1   OBI read response valid (reads only)
//  rdata_o       out  32  OBI read data
//  sram_csb_o    out  1   SRAM chip select, active low
//  sram_web_o    out  1   SRAM write enable, active low
//  sram_wmask_o  out  4   SRAM byte write mask (= be_i)
//  sram_addr_o   out  ADDR_WIDTH  SRAM word address = addr_i[ADDR_WIDTH+1:2]
//  sram_din_o    out  32  SRAM write data (= wdata_i)
//  sram_dout_i   in   32  SRAM read data
//  err_o         out  1   sticky out-of-range flag (0 when OBI_SRAM_RANGE_CHECK_EN undefined)
// BEHAVIOUR
//  Reset (async, rst_ni=0): state=IDLE, lat_cnt=0, rvalid_o=0, rdata_o=0, err_o=0, sram_csb_o=1,
//  sram_web_o=1; any in-flight read is dropped with no rvalid after reset release.
//  FSM IDLE/RD_WAIT. gnt_o = (state==IDLE) | (state==RD_WAIT & rvalid_o); combinational, req-independent.
//  Accept = req_i & gnt_o. On accept: sram_csb_o=0, sram_web_o=~we_i, addr/din/wmask driven same cycle.
//  No accept: sram_csb_o=1, sram_web_o=1, other SRAM outputs don't-care (drive from OBI inputs).
//  Write accept: state stays/returns IDLE; no rvalid ever generated for writes.
//  Read accept in cycle t: state->RD_WAIT, lat_cnt=READ_LATENCY; rvalid_o=1 exactly in cycle
//  t+READ_LATENCY; rdata_o=sram_dout_i in that cycle, 0 otherwise.
//  rvalid cycle with new accept: back-to-back; read restarts RD_WAIT, write returns to IDLE.
//  rvalid cycle without accept: ->IDLE. Throughput: 1 read per READ_LATENCY cycles, 1 write/cycle.
//  addr_i[1:0] ignored; be_i=0 write performs a no-op SRAM write (csb low, mask 0).
//  lat_cnt width clog2(READ_LATENCY+1); never wraps, decrements to 0 then holds.
// CONFIGURATION
//  `OBI_SRAM_RANGE_CHECK_EN defined: access is in range iff addr_i[31:ADDR_WIDTH+2] ==
//  BASE_ADDR[31:ADDR_WIDTH+2]. Out-of-range accept: SRAM not selected (csb=1), err_o set (sticky
//  until reset); read still completes on normal timing with rdata_o=32'hBADC_0FFE.
//  Undefined: upper address bits ignored (aliasing), err_o tied 0, no comparator.
// STRUCTURE
//  obi_pkg: obi_state_e {IDLE, RD_WAIT}, OBI_DATA_W=32, OBI_BE_W=4, OBI_RANGE_ERR_DATA=32'hBADC_0FFE.
//  Sub-module obi_sram_rd_timer: loads READ_LATENCY on read accept, flags rvalid at expiry and
//  carries the per-read out-of-range bit; bridge top holds FSM, address decode, SRAM drive.
// TESTING
//  Reset mid-read (assert rst_ni at t+0 of READ_LATENCY=2 read) -> no rvalid, gnt_o=1 after release.
//  Write addr 0x10 data 0xCAFEF00D be=4'b0011 -> csb=0, web=0, sram_addr=4, wmask=3, no rvalid.
//  Read addr 0x10, SRAM model returns 0x0000F00D, READ_LATENCY=1 -> rvalid=1 next cycle, rdata=0x0000F00D.
//  4 back-to-back reads, READ_LATENCY=3 -> gnt only in rvalid cycles, rvalid every 3 cycles, data in order.
//  Read then write in the rvalid cycle -> write granted same cycle, state IDLE after, single rvalid.
//  RANGE_CHECK_EN, BASE=0, ADDR_WIDTH=10, read 0x1000 -> csb stays 1, rdata=0xBADC0FFE, err_o=1 sticky.

Source files
------------

// File: rtl/obi_pkg.sv
// Shared types and constants for the OBI-to-SRAM bridge.
package obi_pkg;

  localparam int unsigned OBI_DATA_W = 32;
  localparam int unsigned OBI_BE_W   = 4;

  localparam logic [OBI_DATA_W-1:0] OBI_RANGE_ERR_DATA = 32'hBADC_0FFE;

  typedef enum logic [0:0] {
    StIdle,
    StRdWait
  } obi_state_e;

  function automatic int unsigned lat_cnt_width(int unsigned latency);
    return $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/obi_sram_rd_timer.sv
// Read-latency timer: loads READ_LATENCY on a read accept, raises a registered rvalid when the
// SRAM data is due, and carries the out-of-range bit of the read in flight.
module obi_sram_rd_timer
  import obi_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic oor_i,
  output logic rvalid_o,
  output logic oor_o
);

  localparam int unsigned CntW = lat_cnt_width(READ_LATENCY);

  logic [CntW-1:0] lat_cnt_d, lat_cnt_q;
  logic            rvalid_d, rvalid_q;
  logic            oor_d, oor_q;

  // lat_cnt_q holds READ_LATENCY in the first wait cycle, so rvalid is registered when it reaches 2.
  always_comb begin
    lat_cnt_d = lat_cnt_q;
    rvalid_d  = 1'b0;
    oor_d     = oor_q;
    if (start_i) begin
      lat_cnt_d = CntW'(READ_LATENCY);
      rvalid_d  = (READ_LATENCY == 1);
      oor_d     = oor_i;
    end else begin
      if (lat_cnt_q != '0) begin
        lat_cnt_d = lat_cnt_q - CntW'(1);
      end
      rvalid_d = ({1'b0, lat_cnt_q} == (CntW + 1)'(2));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lat_cnt_q <= '0;
      rvalid_q  <= 1'b0;
      oor_q     <= 1'b0;
    end else begin
      lat_cnt_q <= lat_cnt_d;
      rvalid_q  <= rvalid_d;
      oor_q     <= oor_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign oor_o    = oor_q;

endmodule

// File: rtl/obi_sram_bridge.sv
// OBI slave driving one single-port SRAM macro (active-low CS/WE, byte mask); reads only respond.
// Optional address window check enabled by defining OBI_SRAM_RANGE_CHECK_EN.
module obi_sram_bridge
  import obi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [31:0]           addr_i,
  input  logic                  we_i,
  input  logic [OBI_BE_W-1:0]   be_i,
  input  logic [OBI_DATA_W-1:0] wdata_i,
  output logic                  rvalid_o,
  output logic [OBI_DATA_W-1:0] rdata_o,
  output logic                  sram_csb_o,
  output logic                  sram_web_o,
  output logic [OBI_BE_W-1:0]   sram_wmask_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [OBI_DATA_W-1:0] sram_din_o,
  input  logic [OBI_DATA_W-1:0] sram_dout_i,
  output logic                  err_o
);

  obi_state_e state_d, state_q;
  logic       accept;
  logic       in_range;
  logic       sram_sel;
  logic       rd_start;
  logic       rd_oor;

`ifdef OBI_SRAM_RANGE_CHECK_EN
  logic err_q;
  logic unused_addr;

  assign in_range    = (addr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign unused_addr = ^addr_i[1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (accept && !in_range) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  logic unused_addr;

  // Upper address bits alias onto the SRAM.
  assign in_range    = 1'b1;
  assign unused_addr = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0]};
  assign err_o       = 1'b0;
`endif

  assign gnt_o    = (state_q == StIdle) || ((state_q == StRdWait) && rvalid_o);
  assign accept   = req_i && gnt_o;
  assign rd_start = accept && !we_i;

  // Keep the macro deselected while reset is asserted.
  assign sram_sel     = accept && in_range && rst_ni;
  assign sram_csb_o   = !sram_sel;
  assign sram_web_o   = !(sram_sel && we_i);
  assign sram_wmask_o = be_i;
  assign sram_addr_o  = addr_i[ADDR_WIDTH+1:2];
  assign sram_din_o   = wdata_i;

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = we_i ? StIdle : StRdWait;
    end else if ((state_q == StRdWait) && rvalid_o) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  obi_sram_rd_timer #(
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (rd_start),
    .oor_i   (!in_range),
    .rvalid_o(rvalid_o),
    .oor_o   (rd_oor)
  );

  always_comb begin
    rdata_o = '0;
    if (rvalid_o) begin
      rdata_o = rd_oor ? OBI_RANGE_ERR_DATA : sram_dout_i;
    end
  end

endmodule
